// File: rtl/sc_level_progress_counter_pkg.sv
// Shared constants for the RoadFighter level-sequencing interface.
// Both the level state machine and this counter import the same thresholds.
package sc_level_progress_counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LEVEL_MAX    = 7;
    localparam int PROGRESS_MAX = 31;

    // Progress thresholds that the level state machine compares against.
    localparam int PROGRESS_THRESH_LOW  = 17;
    localparam int PROGRESS_THRESH_MID  = 21;
    localparam int PROGRESS_THRESH_HIGH = 30;

endpackage

// File: rtl/sc_level_progress_counter_if.sv
// Strobe/count bundle between the level state machine (master) and the counter (slave).
interface sc_level_progress_counter_if #(
    parameter int LEVEL_WIDTH    = 3,
    parameter int PROGRESS_WIDTH = 5
);
    logic                      SC_LEVELPROGRESS_Start_InLow;
    logic                      SC_LEVELPROGRESS_LevelUp_InLow;
    logic                      SC_LEVELPROGRESS_ProgressUp_InLow;
    logic [LEVEL_WIDTH-1:0]    SC_LEVELPROGRESS_CurrentLevel_Out;
    logic [PROGRESS_WIDTH-1:0] SC_LEVELPROGRESS_ProgressCount_Out;
    logic                      SC_LEVELPROGRESS_LevelChanged_OutLow;
    logic                      SC_LEVELPROGRESS_Done_OutLow;

    modport master (
        output SC_LEVELPROGRESS_Start_InLow,
        output SC_LEVELPROGRESS_LevelUp_InLow,
        output SC_LEVELPROGRESS_ProgressUp_InLow,
        input  SC_LEVELPROGRESS_CurrentLevel_Out,
        input  SC_LEVELPROGRESS_ProgressCount_Out,
        input  SC_LEVELPROGRESS_LevelChanged_OutLow,
        input  SC_LEVELPROGRESS_Done_OutLow
    );

    modport slave (
        input  SC_LEVELPROGRESS_Start_InLow,
        input  SC_LEVELPROGRESS_LevelUp_InLow,
        input  SC_LEVELPROGRESS_ProgressUp_InLow,
        output SC_LEVELPROGRESS_CurrentLevel_Out,
        output SC_LEVELPROGRESS_ProgressCount_Out,
        output SC_LEVELPROGRESS_LevelChanged_OutLow,
        output SC_LEVELPROGRESS_Done_OutLow
    );
endinterface

// File: rtl/sc_level_progress_counter_falling_edge.sv
// Falling-edge detector for an active-low strobe; history clears to 0 so a
// strobe held low across reset release never produces a pulse.
module sc_falling_edge_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic fall_o
);
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= d_i;
        end
    end

    assign fall_o = prev_q & ~d_i;
endmodule

// File: rtl/sc_level_progress_counter.sv
// Level/progress counter: edge-detects the active-low strobes, sequences
// IDLE->RUN->DONE and holds saturating, registered level and progress counts.
module sc_level_progress_counter
    import sc_level_progress_counter_pkg::*;
#(
    parameter int LEVEL_WIDTH    = 3,
    parameter int PROGRESS_WIDTH = 5,
    parameter int LEVEL_MAX      = sc_level_progress_counter_pkg::LEVEL_MAX,
    parameter int PROGRESS_MAX   = sc_level_progress_counter_pkg::PROGRESS_MAX
) (
    input  logic                        SC_LEVELPROGRESS_CLOCK_50,
    input  logic                        SC_LEVELPROGRESS_RESET_InLow,
    sc_level_progress_counter_if.slave  bus
);
    localparam logic [LEVEL_WIDTH-1:0]    LVL_MAX_C  = LEVEL_WIDTH'(LEVEL_MAX);
    localparam logic [LEVEL_WIDTH-1:0]    LVL_ONE_C  = LEVEL_WIDTH'(1);
    localparam logic [PROGRESS_WIDTH-1:0] PROG_MAX_C = PROGRESS_WIDTH'(PROGRESS_MAX);

    function automatic logic [LEVEL_WIDTH-1:0] sat_inc_level(input logic [LEVEL_WIDTH-1:0] v);
        return (v < LVL_MAX_C) ? v + LVL_ONE_C : LVL_MAX_C;
    endfunction

    function automatic logic [PROGRESS_WIDTH-1:0] sat_inc_progress(input logic [PROGRESS_WIDTH-1:0] v);
        return (v < PROG_MAX_C) ? v + PROGRESS_WIDTH'(1) : PROG_MAX_C;
    endfunction

    logic start_fall, level_fall, progress_fall;

    sc_falling_edge_detect u_start_edge (
        .clk_i  (SC_LEVELPROGRESS_CLOCK_50),
        .rst_ni (SC_LEVELPROGRESS_RESET_InLow),
        .d_i    (bus.SC_LEVELPROGRESS_Start_InLow),
        .fall_o (start_fall)
    );

    sc_falling_edge_detect u_level_edge (
        .clk_i  (SC_LEVELPROGRESS_CLOCK_50),
        .rst_ni (SC_LEVELPROGRESS_RESET_InLow),
        .d_i    (bus.SC_LEVELPROGRESS_LevelUp_InLow),
        .fall_o (level_fall)
    );

    sc_falling_edge_detect u_progress_edge (
        .clk_i  (SC_LEVELPROGRESS_CLOCK_50),
        .rst_ni (SC_LEVELPROGRESS_RESET_InLow),
        .d_i    (bus.SC_LEVELPROGRESS_ProgressUp_InLow),
        .fall_o (progress_fall)
    );

    state_t                    state_q, state_d;
    logic [LEVEL_WIDTH-1:0]    level_q, level_d;
    logic [PROGRESS_WIDTH-1:0] progress_q, progress_d;
    logic                      changed_n_q, changed_n_d;
    logic                      done_n_q, done_n_d;

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        progress_d  = progress_q;
        changed_n_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (start_fall) begin
                    level_d     = LVL_ONE_C;
                    progress_d  = '0;
                    changed_n_d = 1'b0;
                    state_d     = (LVL_ONE_C == LVL_MAX_C) ? DONE : RUN;
                end
            end
            RUN: begin
                // Level-up takes priority and discards a coincident progress fall.
                if (level_fall && (level_q < LVL_MAX_C)) begin
                    level_d     = sat_inc_level(level_q);
                    progress_d  = '0;
                    changed_n_d = 1'b0;
                    if (level_d == LVL_MAX_C) begin
                        state_d = DONE;
                    end
                end else if (progress_fall) begin
                    progress_d = sat_inc_progress(progress_q);
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d    = IDLE;
                level_d    = '0;
                progress_d = '0;
            end
        endcase
        done_n_d = (level_d != LVL_MAX_C);
    end

    always_ff @(posedge SC_LEVELPROGRESS_CLOCK_50) begin
        if (!SC_LEVELPROGRESS_RESET_InLow) begin
            state_q     <= IDLE;
            level_q     <= '0;
            progress_q  <= '0;
            changed_n_q <= 1'b1;
            done_n_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            progress_q  <= progress_d;
            changed_n_q <= changed_n_d;
            done_n_q    <= done_n_d;
        end
    end

    assign bus.SC_LEVELPROGRESS_CurrentLevel_Out    = level_q;
    assign bus.SC_LEVELPROGRESS_ProgressCount_Out   = progress_q;
    assign bus.SC_LEVELPROGRESS_LevelChanged_OutLow = changed_n_q;
    assign bus.SC_LEVELPROGRESS_Done_OutLow         = done_n_q;
endmodule

// File: tb/tb_sc_level_progress_counter.sv
// Scenario bench for sc_level_progress_counter: each task queues per-cycle
// stimulus with its expected outputs, then drains and compares them.
module tb_sc_level_progress_counter;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    sc_level_progress_counter_if #(.LEVEL_WIDTH(3), .PROGRESS_WIDTH(5)) bus ();

    sc_level_progress_counter #(
        .LEVEL_WIDTH(3), .PROGRESS_WIDTH(5), .LEVEL_MAX(7), .PROGRESS_MAX(31)
    ) dut (
        .SC_LEVELPROGRESS_CLOCK_50    (clk),
        .SC_LEVELPROGRESS_RESET_InLow (rst_n),
        .bus                          (bus)
    );

    typedef struct {
        logic r, s, l, p;
    } stim_t;

    typedef struct {
        logic [9:0] v;
        string      name;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    n_run  = 0;
    int    n_fail = 0;

    function automatic logic [9:0] obs();
        return {bus.SC_LEVELPROGRESS_CurrentLevel_Out,
                bus.SC_LEVELPROGRESS_ProgressCount_Out,
                bus.SC_LEVELPROGRESS_LevelChanged_OutLow,
                bus.SC_LEVELPROGRESS_Done_OutLow};
    endfunction

    // Inputs change just after a falling edge; outputs are read at the next falling edge.
    task automatic drive(input stim_t st);
        rst_n                                 = st.r;
        bus.SC_LEVELPROGRESS_Start_InLow      = st.s;
        bus.SC_LEVELPROGRESS_LevelUp_InLow    = st.l;
        bus.SC_LEVELPROGRESS_ProgressUp_InLow = st.p;
        @(negedge clk);
    endtask

    task automatic add(input logic r, s, l, p, input string n,
                       input int lvl, prog, input logic chg, dn);
        stim_t st;
        exp_t  e;
        st.r = r; st.s = s; st.l = l; st.p = p;
        e.v    = {3'(lvl), 5'(prog), chg, dn};
        e.name = n;
        stim_q.push_back(st);
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        add(0, 1, 1, 1, "reset_state", 0, 0, 1, 1);
        add(0, 1, 1, 1, "reset_state", 0, 0, 1, 1);
        add(1, 1, 1, 1, "reset_release", 0, 0, 1, 1);
        add(1, 1, 0, 1, "idle_ignores_levelup", 0, 0, 1, 1);
        add(1, 1, 1, 0, "idle_ignores_progress", 0, 0, 1, 1);
        add(1, 1, 1, 1, "idle_quiet", 0, 0, 1, 1);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_run++;
            if (obs() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", e.name, obs(), e.v);
            end
        end
    endtask

    task automatic test_start();
        exp_t e;
        add(1, 0, 1, 1, "start_enters_level1", 1, 0, 0, 1);
        add(1, 1, 1, 1, "start_pulse_one_cycle", 1, 0, 1, 1);
        add(1, 0, 1, 1, "run_ignores_start", 1, 0, 1, 1);
        add(1, 1, 1, 1, "run_quiet", 1, 0, 1, 1);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_run++;
            if (obs() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", e.name, obs(), e.v);
            end
        end
    endtask

    task automatic test_progress_and_hold();
        exp_t e;
        for (int k = 1; k <= 17; k++) begin
            add(1, 1, 1, 0, "progress_count", 1, k, 1, 1);
            add(1, 1, 1, 1, "progress_count", 1, k, 1, 1);
        end
        for (int k = 0; k < 21; k++) begin
            add(1, 1, (k < 20) ? 1'b0 : 1'b1, 1, "levelup_held_single",
                2, 0, (k == 0) ? 1'b0 : 1'b1, 1);
        end
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_run++;
            if (obs() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", e.name, obs(), e.v);
            end
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        add(1, 1, 0, 1, "levelup_to_3", 3, 0, 0, 1);
        add(1, 1, 1, 1, "levelup_to_3", 3, 0, 1, 1);
        for (int k = 1; k <= 9; k++) begin
            add(1, 1, 1, 0, "progress_to_9", 3, k, 1, 1);
            add(1, 1, 1, 1, "progress_to_9", 3, k, 1, 1);
        end
        add(1, 1, 0, 0, "simultaneous_levelup_wins", 4, 0, 0, 1);
        add(1, 1, 1, 1, "simultaneous_after", 4, 0, 1, 1);
        add(1, 1, 1, 1, "progress_not_deferred", 4, 0, 1, 1);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_run++;
            if (obs() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", e.name, obs(), e.v);
            end
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        for (int k = 1; k <= 40; k++) begin
            add(1, 1, 1, 0, "progress_saturate", 4, (k > 31) ? 31 : k, 1, 1);
            add(1, 1, 1, 1, "progress_saturate", 4, (k > 31) ? 31 : k, 1, 1);
        end
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_run++;
            if (obs() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", e.name, obs(), e.v);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        add(1, 1, 0, 1, "levelup_to_5", 5, 0, 0, 1);
        add(1, 1, 1, 1, "levelup_to_5", 5, 0, 1, 1);
        for (int k = 1; k <= 12; k++) begin
            add(1, 1, 1, 0, "progress_to_12", 5, k, 1, 1);
            add(1, 1, 1, 1, "progress_to_12", 5, k, 1, 1);
        end
        // Reset arrives together with the LevelUp fall; Start is also held low.
        add(0, 0, 0, 1, "reset_wins_over_levelup", 0, 0, 1, 1);
        add(0, 0, 0, 1, "reset_held", 0, 0, 1, 1);
        for (int k = 0; k < 3; k++) add(1, 0, 0, 1, "held_low_through_release", 0, 0, 1, 1);
        add(1, 1, 0, 1, "start_returns_high", 0, 0, 1, 1);
        add(1, 0, 0, 1, "start_fresh_fall", 1, 0, 0, 1);
        add(1, 1, 0, 1, "levelup_held_ignored", 1, 0, 1, 1);
        add(1, 1, 0, 1, "levelup_held_ignored", 1, 0, 1, 1);
        add(1, 1, 1, 1, "levelup_released", 1, 0, 1, 1);
        add(1, 1, 0, 1, "levelup_fresh_fall", 2, 0, 0, 1);
        add(1, 1, 1, 1, "levelup_fresh_fall_end", 2, 0, 1, 1);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_run++;
            if (obs() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", e.name, obs(), e.v);
            end
        end
    endtask

    task automatic test_done();
        exp_t e;
        for (int lv = 3; lv <= 7; lv++) begin
            add(1, 1, 0, 1, "climb_to_done", lv, 0, 0, (lv == 7) ? 1'b0 : 1'b1);
            add(1, 1, 1, 1, "climb_to_done", lv, 0, 1, (lv == 7) ? 1'b0 : 1'b1);
        end
        add(1, 1, 0, 1, "done_ignores_levelup", 7, 0, 1, 0);
        add(1, 1, 1, 1, "done_hold", 7, 0, 1, 0);
        add(1, 1, 1, 0, "done_ignores_progress", 7, 0, 1, 0);
        add(1, 1, 1, 1, "done_hold", 7, 0, 1, 0);
        add(1, 0, 1, 1, "done_ignores_start", 7, 0, 1, 0);
        add(1, 1, 1, 1, "done_hold", 7, 0, 1, 0);
        add(1, 0, 0, 0, "done_ignores_all", 7, 0, 1, 0);
        add(1, 1, 1, 1, "done_hold", 7, 0, 1, 0);
        add(0, 1, 1, 1, "reset_exits_done", 0, 0, 1, 1);
        while (stim_q.size() > 0) begin
            drive(stim_q.pop_front());
            e = exp_q.pop_front();
            n_run++;
            if (obs() !== e.v) begin
                n_fail++;
                $display("FAIL %s: got %b required %b", e.name, obs(), e.v);
            end
        end
    endtask

    initial begin
        rst_n                                 = 1'b0;
        bus.SC_LEVELPROGRESS_Start_InLow      = 1'b1;
        bus.SC_LEVELPROGRESS_LevelUp_InLow    = 1'b1;
        bus.SC_LEVELPROGRESS_ProgressUp_InLow = 1'b1;
        test_reset();
        test_start();
        test_progress_and_hold();
        test_simultaneous();
        test_saturation();
        test_reset_mid();
        test_done();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
